// File: rtl/fb_pkg.sv
// Shared constants, write-FSM encoding and pixel address helper
// for the 160x120 plot-interface framebuffer sink.
package fb_pkg;

  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int FB_DEPTH = H_RES * V_RES;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wr_state_t;

  // y*160 + x as two shifts and adds
  function automatic logic [ADDR_W-1:0] xy_to_addr(
    input logic [7:0] x,
    input logic [6:0] y
  );
    logic [ADDR_W-1:0] yy;
    yy = {8'd0, y};
    return (yy << 7) + (yy << 5) + {7'd0, x};
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one
// registered read port, read-first, contents not reset.
module fb_ram #(
  parameter int DEPTH = fb_pkg::FB_DEPTH,
  parameter int AW    = fb_pkg::ADDR_W,
  parameter int DW    = fb_pkg::COLOUR_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_plot_sink.sv
// Plot-interface sink: clears and stores pixels into a framebuffer
// and scans it out in raster order as a paced pixel stream.
module fb_plot_sink #(
  parameter int H_RES   = fb_pkg::H_RES,
  parameter int V_RES   = fb_pkg::V_RES,
  parameter int PIX_DIV = 4,
  parameter logic [fb_pkg::COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        plot,
  input  logic [7:0]                  x,
  input  logic [6:0]                  y,
  input  logic [fb_pkg::COLOUR_W-1:0] colour,
  input  logic                        scan_en,
  output logic                        busy,
  output logic                        oob_err,
  output logic                        pix_valid,
  output logic [7:0]                  pix_x,
  output logic [6:0]                  pix_y,
  output logic [fb_pkg::COLOUR_W-1:0] pix_colour,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [7:0]                  frame_count
);

  import fb_pkg::*;

  localparam int DEPTH = H_RES * V_RES;
  localparam int DIV_W = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [7:0] X_LIM  = 8'(H_RES);
  localparam logic [6:0] Y_LIM  = 7'(V_RES);
  localparam logic [7:0] X_LAST = 8'(H_RES - 1);
  localparam logic [6:0] Y_LAST = 7'(V_RES - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  // shift form for the native resolution, generic otherwise
  function automatic logic [ADDR_W-1:0] to_addr(
    input logic [7:0] xx,
    input logic [6:0] yy
  );
    if (H_RES == fb_pkg::H_RES) return xy_to_addr(xx, yy);
    return ADDR_W'(yy) * ADDR_W'(H_RES) + ADDR_W'(xx);
  endfunction

  wr_state_t state, state_nxt;

  logic [ADDR_W-1:0]   clr_addr;
  logic [ADDR_W-1:0]   waddr;
  logic [ADDR_W-1:0]   raddr;
  logic [COLOUR_W-1:0] wdata;
  logic [COLOUR_W-1:0] rdata;
  logic                we;
  logic                in_range;
  logic                oob_set;
  logic                tick;
  logic                have_pix;
  logic [DIV_W-1:0]    div;
  logic [7:0]          sx;
  logic [6:0]          sy;

  assign in_range = (x < X_LIM) && (y < Y_LIM);
  assign busy     = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    we        = 1'b0;
    waddr     = to_addr(x, y);
    wdata     = colour;
    oob_set   = 1'b0;
    unique case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr;
        wdata = CLEAR_COLOUR;
        if (clr_addr == CLR_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (plot) begin
          we      = in_range;
          oob_set = ~in_range;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= CLEAR;
      clr_addr <= '0;
      oob_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
      if (oob_set) oob_err <= 1'b1;
    end
  end

  assign tick  = scan_en && (div == DIV_LAST);
  assign raddr = to_addr(sx, sy);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div         <= '0;
      sx          <= '0;
      sy          <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      have_pix    <= 1'b0;
      frame_count <= '0;
    end else begin
      pix_valid <= tick;
      if (scan_en) div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        pix_x    <= sx;
        pix_y    <= sy;
        have_pix <= 1'b1;
        if (sx == X_LAST) begin
          sx <= '0;
          if (sy == Y_LAST) begin
            sy          <= '0;
            frame_count <= frame_count + 1'b1;
          end else begin
            sy <= sy + 1'b1;
          end
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

  // RAM output register has no reset; mask it until the first read
  assign pix_colour  = have_pix ? rdata : '0;
  assign line_start  = pix_valid && (pix_x == 8'd0);
  assign frame_start = line_start && (pix_y == 7'd0);

  fb_ram #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (COLOUR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (tick),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fb_plot_sink.sv
// Bench for fb_plot_sink: full-size instance against a pixel-array
// model, plus a tiny instance for pacing and frame_count wrap.
module tb_fb_plot_sink;

  localparam int H     = 160;
  localparam int V     = 120;
  localparam int DEPTH = H * V;
  localparam int DIV   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn  = 1'b0;
  logic       plot    = 1'b0;
  logic [7:0] x       = '0;
  logic [6:0] y       = '0;
  logic [2:0] colour  = '0;
  logic       scan_en = 1'b0;
  logic       busy, oob_err, pix_valid, line_start, frame_start;
  logic [7:0] pix_x, frame_count;
  logic [6:0] pix_y;
  logic [2:0] pix_colour;

  logic       s_resetn  = 1'b0;
  logic       s_plot    = 1'b0;
  logic [7:0] s_x       = '0;
  logic [6:0] s_y       = '0;
  logic [2:0] s_colour  = '0;
  logic       s_scan_en = 1'b0;
  logic       s_busy, s_oob_err, s_pix_valid, s_line_start;
  logic       s_frame_start;
  logic [7:0] s_pix_x, s_frame_count;
  logic [6:0] s_pix_y;
  logic [2:0] s_pix_colour;

  fb_plot_sink #(.PIX_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y),
    .colour(colour), .scan_en(scan_en), .busy(busy),
    .oob_err(oob_err), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_y(pix_y), .pix_colour(pix_colour),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  fb_plot_sink #(.H_RES(8), .V_RES(4), .PIX_DIV(4)) dut_s (
    .clk(clk), .resetn(s_resetn), .plot(s_plot), .x(s_x),
    .y(s_y), .colour(s_colour), .scan_en(s_scan_en),
    .busy(s_busy), .oob_err(s_oob_err),
    .pix_valid(s_pix_valid), .pix_x(s_pix_x), .pix_y(s_pix_y),
    .pix_colour(s_pix_colour), .line_start(s_line_start),
    .frame_start(s_frame_start), .frame_count(s_frame_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // model: pixel array, clear countdown, pixel index, enabled cycles
  logic [2:0] mem [DEPTH];
  int   clr_left = DEPTH;
  int   en_cnt   = 0;
  int   idx      = 0;
  int   e_x = 0, e_y = 0, e_fc = 0;
  logic [2:0] e_col = '0;
  bit   e_valid = 1'b0;
  bit   m_oob   = 1'b0;

  task automatic model_step();
    bit tk;
    if (!resetn) begin
      clr_left = DEPTH; en_cnt = 0; idx = 0; m_oob = 1'b0;
      e_x = 0; e_y = 0; e_fc = 0; e_col = '0; e_valid = 1'b0;
      return;
    end
    tk = 1'b0;
    if (scan_en) begin
      en_cnt++;
      tk = (en_cnt % DIV) == 0;
    end
    e_valid = tk;
    if (tk) begin
      e_x   = idx % H;
      e_y   = idx / H;
      e_col = mem[idx];
      idx++;
      if (idx == DEPTH) begin
        idx  = 0;
        e_fc = (e_fc + 1) % 256;
      end
    end
    if (clr_left > 0) begin
      mem[DEPTH - clr_left] = 3'b000;
      clr_left--;
    end else if (plot) begin
      if (x < H && y < V) mem[y * H + x] = colour;
      else m_oob = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 3'b000;
    forever begin
      @(posedge clk or negedge resetn);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("busy", busy, clr_left > 0);
    chk("oob_err", oob_err, m_oob);
    chk("pix_valid", pix_valid, e_valid);
    chk("pix_x", pix_x, e_x);
    chk("pix_y", pix_y, e_y);
    chk("pix_colour", pix_colour, e_col);
    chk("line_start", line_start, e_valid && e_x == 0);
    chk("frame_start", frame_start,
        e_valid && e_x == 0 && e_y == 0);
    chk("frame_count", frame_count, e_fc);
  end

  int sn = 0;
  bit seen255 = 1'b0;

  initial forever begin
    @(negedge clk);
    if (s_resetn && s_pix_valid) begin
      chk("s_pix_x", s_pix_x, sn % 8);
      chk("s_pix_y", s_pix_y, (sn / 8) % 4);
      chk("s_pix_colour", s_pix_colour, 0);
      chk("s_line_start", s_line_start, sn % 8 == 0);
      chk("s_frame_start", s_frame_start, sn % 32 == 0);
      chk("s_frame_count", s_frame_count, ((sn + 1) / 32) % 256);
      chk("s_oob_err", s_oob_err, 0);
      if (s_frame_count == 8'd255) seen255 = 1'b1;
      sn++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_plot(input logic [7:0] px,
                         input logic [6:0] py,
                         input logic [2:0] pc);
    x = px; y = py; colour = pc; plot = 1'b1;
    cyc();
    plot = 1'b0;
  endtask

  task automatic wait_pix(input int wx, input int wy);
    int n;
    for (n = 0; n < 40000; n++) begin
      cyc();
      if (pix_valid && pix_x == wx && pix_y == wy) break;
    end
    if (n >= 40000) timeout("wait_pix");
  endtask

  task automatic run_small();
    int n;
    n = 0;
    while (s_busy && n < 100) begin cyc(); n++; end
    s_scan_en = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!s_pix_valid && n < 10);
    chk("s_first_latency", n, 4);
    n = 0;
    while (sn < 8192 && n < 40000) begin cyc(); n++; end
    if (n >= 40000) timeout("s_frames");
    chk("s_wrap_count", s_frame_count, 0);
    chk("s_seen255", seen255, 1);
  endtask

  task automatic run_big();
    int n;
    x = 8'd5; y = 7'd5; colour = 3'b111;
    for (int c = 1; c <= 10000; c++) begin
      cyc();
      plot = (c == 99);
      if (c == 200) scan_en = 1'b1;
    end
    chk("oob_in_clear", oob_err, 0);
    chk("busy_mid_clear", busy, 1);
    resetn = 1'b0;
    scan_en = 1'b0;
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_fc", frame_count, 0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    n = 0;
    while (busy && n < 20001) begin cyc(); n++; end
    chk("clear_len", n, 19200);

    do_plot(8'd0, 7'd0, 3'b001);
    do_plot(8'd159, 7'd0, 3'b010);
    do_plot(8'd0, 7'd119, 3'b100);
    do_plot(8'd159, 7'd119, 3'b111);
    do_plot(8'd160, 7'd10, 3'b101);
    chk("oob_first", oob_err, 1);
    do_plot(8'd10, 7'd120, 3'b101);

    scan_en = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!pix_valid && n < 10);
    chk("first_latency", n, DIV);
    chk("first_x", pix_x, 0);
    chk("first_colour", pix_colour, 3'b001);
    chk("first_fs", frame_start, 1);
    chk("first_ls", line_start, 1);

    wait_pix(159, 0);
    chk("pix159", pix_colour, 3'b010);

    wait_pix(80, 1);
    scan_en = 1'b0;
    n = 0;
    repeat (50) begin cyc(); if (pix_valid) n++; end
    chk("gap_valids", n, 0);
    scan_en = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!pix_valid && n < 10);
    chk("resume_x", pix_x, 81);
    chk("resume_y", pix_y, 1);

    wait_pix(19, 30);
    cyc();
    x = 8'd20; y = 7'd30; colour = 3'b101; plot = 1'b1;
    cyc();
    plot = 1'b0;
    chk("raw_valid", pix_valid, 1);
    chk("raw_x", pix_x, 20);
    chk("raw_old", pix_colour, 3'b000);

    wait_pix(0, 119);
    chk("pix19040", pix_colour, 3'b100);
    chk("pix19040_ls", line_start, 1);
    wait_pix(159, 119);
    chk("pix19199", pix_colour, 3'b111);
    chk("fc_after_frame", frame_count, 1);
    wait_pix(20, 30);
    chk("raw_new", pix_colour, 3'b101);

    chk("oob_sticky", oob_err, 1);
    resetn = 1'b0;
    #1;
    chk("oob_reset", oob_err, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    resetn   = 1'b1;
    s_resetn = 1'b1;
    fork
      run_big();
      run_small();
    join
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
